// File: rtl/fixed_requant_pkg.sv
// ----------------------------------------------------------------------------
// fixed_requant_pkg
// Shared constants and arithmetic helpers for the fixed-point requantiser.
// The helpers work on a wide signed calculation type so that the rounding
// add can never overflow, whatever word widths the instantiating module uses.
// Callers truncate the result to their own register width.
// ----------------------------------------------------------------------------
package fixed_requant_pkg;

    // Width of the saturation event counter.
    localparam int SAT_CNT_W = 16;

    // Working width for shift/round/clamp arithmetic.
    localparam int CALC_W = 64;

    typedef logic signed [CALC_W-1:0] calc_t;

    // d > 0 : add half an output LSB, then arithmetic shift right
    //         (round half toward +inf).
    // d <= 0: arithmetic shift left, no rounding needed.
    function automatic calc_t round_shift(input calc_t x, input int d);
        calc_t r;
        if (d > 0) begin
            r = (x + (calc_t'(1) <<< (d - 1))) >>> d;
        end else begin
            r = x <<< (-d);
        end
        return r;
    endfunction

    function automatic calc_t clamp_max(input int w);
        return (calc_t'(1) <<< (w - 1)) - calc_t'(1);
    endfunction

    function automatic calc_t clamp_min(input int w);
        return -(calc_t'(1) <<< (w - 1));
    endfunction

    // Clamp x into the signed range of a w-bit word.
    function automatic calc_t saturate(input calc_t x, input int w);
        calc_t r;
        if (x > clamp_max(w)) begin
            r = clamp_max(w);
        end else if (x < clamp_min(w)) begin
            r = clamp_min(w);
        end else begin
            r = x;
        end
        return r;
    endfunction

    // True when saturate() would change the value.
    function automatic logic is_saturated(input calc_t x, input int w);
        return (x > clamp_max(w)) || (x < clamp_min(w));
    endfunction

endpackage

// File: rtl/fixed_requant_lane.sv
// ----------------------------------------------------------------------------
// fixed_requant_lane
// Combinational arithmetic for one lane. The two halves feed different
// pipeline stages of the top module:
//   raw_i  -> rnd_o               : shift and round (feeds stage 1 register)
//   wide_i -> sat_o, sat_flag_o   : clamp to output width (feeds stage 2)
// Ports:
//   raw_i       input  IN_W   signed input sample
//   rnd_o       output WIDE_W shifted/rounded sample
//   wide_i      input  WIDE_W registered rounded sample
//   sat_o       output OUT_W  clamped output sample
//   sat_flag_o  output 1      clamping changed the value
// ----------------------------------------------------------------------------
module fixed_requant_lane
    import fixed_requant_pkg::*;
#(
    parameter int IN_W     = 16,
    parameter int IN_FRAC  = 8,
    parameter int OUT_W    = 8,
    parameter int OUT_FRAC = 4,
    parameter int WIDE_W   = 13
) (
    input  logic signed [IN_W-1:0]   raw_i,
    output logic signed [WIDE_W-1:0] rnd_o,
    input  logic signed [WIDE_W-1:0] wide_i,
    output logic signed [OUT_W-1:0]  sat_o,
    output logic                     sat_flag_o
);

    localparam int SHIFT = IN_FRAC - OUT_FRAC;

    always_comb begin
        rnd_o      = WIDE_W'(round_shift(calc_t'(raw_i), SHIFT));
        sat_o      = OUT_W'(saturate(calc_t'(wide_i), OUT_W));
        sat_flag_o = is_saturated(calc_t'(wide_i), OUT_W);
    end

endmodule

// File: rtl/fixed_requant_pipe.sv
// ----------------------------------------------------------------------------
// fixed_requant_pipe
// Two-stage valid/ready pipeline that requantises P signed fixed-point lanes
// from DATA_IN_0_PRECISION_0/_1 (width/frac) to DATA_OUT_0_PRECISION_0/_1.
//   Stage 1: shift and round, registered at full rounded width.
//   Stage 2: saturate to output width, registered onto the output.
// Ports:
//   clk               rising-edge clock
//   rst               asynchronous active-low reset
//   data_in_0         P signed input lanes
//   data_in_0_valid   input beat valid
//   data_in_0_ready   input beat accepted when high with valid
//   data_out_0        P signed output lanes
//   data_out_0_valid  output beat valid
//   data_out_0_ready  downstream ready
//   data_out_0_last   final beat of a frame (IN_0_DEPTH beats per frame)
//   sat_count         count of output beats with a saturated lane
// Build option: define FIXED_REQUANT_SAT_CNT_EN to enable sat_count; when
// undefined sat_count is tied to zero.
// ----------------------------------------------------------------------------
module fixed_requant_pipe
    import fixed_requant_pkg::*;
#(
    parameter int DATA_IN_0_PRECISION_0       = 16,
    parameter int DATA_IN_0_PRECISION_1       = 8,
    parameter int DATA_OUT_0_PRECISION_0      = 8,
    parameter int DATA_OUT_0_PRECISION_1      = 4,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 10,
    parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic signed [DATA_IN_0_PRECISION_0-1:0]  data_in_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
    input  logic                                     data_in_0_valid,
    output logic                                     data_in_0_ready,
    output logic signed [DATA_OUT_0_PRECISION_0-1:0] data_out_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
    output logic                                     data_out_0_valid,
    input  logic                                     data_out_0_ready,
    output logic                                     data_out_0_last,
    output logic [SAT_CNT_W-1:0]                     sat_count
);

    localparam int P      = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
    localparam int IN_W   = DATA_IN_0_PRECISION_0;
    localparam int OUT_W  = DATA_OUT_0_PRECISION_0;
    localparam int SHIFT  = DATA_IN_0_PRECISION_1 - DATA_OUT_0_PRECISION_1;
    // Rounded value needs one extra bit when shifting right (the +half can
    // carry), and -SHIFT extra bits when shifting left.
    localparam int WIDE_W = (SHIFT > 0) ? (IN_W - SHIFT + 1) : (IN_W - SHIFT);
    localparam int IN_0_DEPTH = (DATA_IN_0_TENSOR_SIZE_DIM_0 + DATA_IN_0_PARALLELISM_DIM_0 - 1)
                                / DATA_IN_0_PARALLELISM_DIM_0;
    localparam int CNT_W = (IN_0_DEPTH > 1) ? $clog2(IN_0_DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_0_DEPTH - 1);

    // Lane arithmetic results
    logic signed [WIDE_W-1:0] lane_rnd [P];
    logic signed [OUT_W-1:0]  lane_sat [P];
    logic [P-1:0]             lane_flag;

    // Pipeline state
    logic                     rdy_en_q;
    logic                     vld_p1_q, vld_p1_d;
    logic signed [WIDE_W-1:0] rnd_p1_q [P];
    logic signed [WIDE_W-1:0] rnd_p1_d [P];
    logic                     vld_p2_q, vld_p2_d;
    logic signed [OUT_W-1:0]  out_p2_q [P];
    logic signed [OUT_W-1:0]  out_p2_d [P];
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic adv_p1;
    logic out_fire;

    for (genvar g = 0; g < P; g++) begin : g_lane
        fixed_requant_lane #(
            .IN_W     (IN_W),
            .IN_FRAC  (DATA_IN_0_PRECISION_1),
            .OUT_W    (OUT_W),
            .OUT_FRAC (DATA_OUT_0_PRECISION_1),
            .WIDE_W   (WIDE_W)
        ) u_lane (
            .raw_i      (data_in_0[g]),
            .rnd_o      (lane_rnd[g]),
            .wide_i     (rnd_p1_q[g]),
            .sat_o      (lane_sat[g]),
            .sat_flag_o (lane_flag[g])
        );
    end

    always_comb begin
        // Stage 1 may hand its beat on whenever stage 2 is empty or draining.
        adv_p1          = !vld_p2_q || data_out_0_ready;
        // rdy_en_q keeps ready low through reset and until the first edge after.
        data_in_0_ready = rdy_en_q && (!vld_p1_q || adv_p1);
        out_fire        = vld_p2_q && data_out_0_ready;

        vld_p1_d = vld_p1_q;
        rnd_p1_d = rnd_p1_q;
        vld_p2_d = vld_p2_q;
        out_p2_d = out_p2_q;
        cnt_d    = cnt_q;

        // ---- stage 1: shift and round ----
        if (data_in_0_ready) begin
            vld_p1_d = data_in_0_valid;
            if (data_in_0_valid) begin
                rnd_p1_d = lane_rnd;
            end
        end

        // ---- stage 2: saturate and register ----
        if (adv_p1) begin
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                out_p2_d = lane_sat;
            end
        end

        // Frame position of the beat currently on the output.
        if (out_fire) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_en_q <= 1'b0;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            cnt_q    <= '0;
            rnd_p1_q <= '{default: '0};
            out_p2_q <= '{default: '0};
        end else begin
            rdy_en_q <= 1'b1;
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            cnt_q    <= cnt_d;
            rnd_p1_q <= rnd_p1_d;
            out_p2_q <= out_p2_d;
        end
    end

    assign data_out_0       = out_p2_q;
    assign data_out_0_valid = vld_p2_q;
    assign data_out_0_last  = vld_p2_q && (cnt_q == CNT_LAST);

`ifdef FIXED_REQUANT_SAT_CNT_EN
    logic                 sat_p2_q, sat_p2_d;
    logic [SAT_CNT_W-1:0] sat_cnt_q, sat_cnt_d;

    always_comb begin
        sat_p2_d  = sat_p2_q;
        sat_cnt_d = sat_cnt_q;
        // Saturation flag travels with the beat into stage 2.
        if (adv_p1 && vld_p1_q) begin
            sat_p2_d = |lane_flag;
        end
        // One count per transferred beat with any saturated lane; sticks at max.
        if (out_fire && sat_p2_q && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_p2_q  <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            sat_p2_q  <= sat_p2_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_count = sat_cnt_q;
`else
    logic sat_unused;
    assign sat_unused = ^lane_flag;
    assign sat_count  = '0;
`endif

endmodule

// File: tb/tb_fixed_requant_pipe.sv
// ----------------------------------------------------------------------------
// tb_fixed_requant_pipe
// Self-checking bench for fixed_requant_pipe at default parameters
// (IN 16/8, OUT 8/4, 10 beats per frame, one lane). Expected values come from
// a hand-derived vector table and from a real-arithmetic reference model.
// sat_count expectations follow FIXED_REQUANT_SAT_CNT_EN.
// ----------------------------------------------------------------------------
module tb_fixed_requant_pipe;

    localparam int IN_W   = 16;
    localparam int IN_F   = 8;
    localparam int OUT_W  = 8;
    localparam int OUT_F  = 4;
    localparam int DEPTH  = 10;
    localparam int BOUND  = 2000;
`ifdef FIXED_REQUANT_SAT_CNT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic signed [IN_W-1:0]  din [1];
    logic                    din_valid;
    logic                    din_ready;
    logic signed [OUT_W-1:0] dout [1];
    logic                    dout_valid;
    logic                    dout_ready;
    logic                    dout_last;
    logic [15:0]             sat_count;

    always #5 clk = ~clk;

    fixed_requant_pipe dut (
        .clk              (clk),
        .rst              (rst),
        .data_in_0        (din),
        .data_in_0_valid  (din_valid),
        .data_in_0_ready  (din_ready),
        .data_out_0       (dout),
        .data_out_0_valid (dout_valid),
        .data_out_0_ready (dout_ready),
        .data_out_0_last  (dout_last),
        .sat_count        (sat_count)
    );

    typedef struct {
        logic [15:0] din;
        logic [7:0]  dout;
        bit          sat;
    } vec_t;

    typedef struct {
        logic [7:0] y;
        bit         s;
    } exp_t;

    int checks = 0;
    int errors = 0;
    int out_idx = 0;
    int exp_sat = 0;
    int last_hits = 0;
    logic [15:0] stim_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: value/2^IN_F rescaled to OUT_F fraction bits, rounded half up,
    // then clamped to the signed OUT_W range.
    function automatic void model(input logic [15:0] x, output logic [7:0] y, output bit s);
        int  v, r, lo, hi;
        real scaled;
        v      = int'($signed(x));
        scaled = real'(v) * (2.0 ** OUT_F) / (2.0 ** IN_F);
        if (IN_F > OUT_F) r = $rtoi($floor(scaled + 0.5));
        else              r = $rtoi(scaled);
        lo = -(2 ** (OUT_W - 1));
        hi = (2 ** (OUT_W - 1)) - 1;
        s  = (r < lo) || (r > hi);
        if (r < lo) r = lo;
        if (r > hi) r = hi;
        y = r[7:0];
    endfunction

    // Streams stim_q through the DUT. mode 0: sink always ready,
    // 1: random valid and ready, 2: sink stalled for the first 5 cycles.
    task automatic run_stream(input int mode);
        exp_t expq [$];
        exp_t e;
        int   n, sent, got, cyc;
        bit   bp_chk;
        n = stim_q.size(); sent = 0; got = 0; cyc = 0; bp_chk = 0;
        while (got < n && cyc < BOUND) begin
            @(negedge clk);
            case (mode)
                1:       dout_ready = 1'($urandom_range(0, 1));
                2:       dout_ready = (cyc >= 5);
                default: dout_ready = 1'b1;
            endcase
            if (sent < n) begin
                din[0]    = stim_q[sent];
                din_valid = (mode != 1) || ($urandom_range(0, 3) != 0);
            end else begin
                din_valid = 1'b0;
            end
            #1;
            if (mode == 2 && sent == 2 && !bp_chk) begin
                bp_chk = 1;
                check("bp_in_ready_low", din_ready, 0);
            end
            if (dout_valid) begin
                if (expq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL stream_extra: got beat %0h, expected no output", $unsigned(dout[0]));
                end else begin
                    check("stream_data", $unsigned(dout[0]), expq[0].y);
                    if (dout_ready) begin
                        check("stream_last", dout_last, (out_idx % DEPTH) == DEPTH - 1);
                        if (dout_last) last_hits++;
                        if (expq[0].s && SAT_EN) exp_sat++;
                        out_idx++;
                        got++;
                        void'(expq.pop_front());
                    end
                end
            end
            if (din_valid && din_ready) begin
                model(stim_q[sent], e.y, e.s);
                expq.push_back(e);
                sent++;
            end
            @(posedge clk);
            cyc++;
        end
        if (got < n) begin
            checks++; errors++;
            $display("FAIL stream_timeout: got %0d beats, expected %0d", got, n);
        end
        din_valid = 1'b0;
        @(negedge clk);
        check("stream_sat_count", sat_count, exp_sat);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", dout_valid, 0);
        check("rst_out_last", dout_last, 0);
        check("rst_sat_count", sat_count, 0);
        check("rst_in_ready", din_ready, 0);
        check("rst_out_data", $unsigned(dout[0]), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        out_idx = 0;
        exp_sat = 0;
        @(posedge clk);
        #1;
        check("release_in_ready", din_ready, 1);
    endtask

    vec_t tbl [13];
    int   lat;

    initial begin
        tbl[0]  = '{16'h0180, 8'h18, 1'b0};
        tbl[1]  = '{16'h0188, 8'h19, 1'b0};
        tbl[2]  = '{16'h7F00, 8'h7F, 1'b1};
        tbl[3]  = '{16'hF7F0, 8'h80, 1'b1};
        tbl[4]  = '{16'hF800, 8'h80, 1'b0};
        tbl[5]  = '{16'h0000, 8'h00, 1'b0};
        tbl[6]  = '{16'hFFF8, 8'h00, 1'b0};
        tbl[7]  = '{16'hFFF7, 8'hFF, 1'b0};
        tbl[8]  = '{16'h07F7, 8'h7F, 1'b0};
        tbl[9]  = '{16'h07F8, 8'h7F, 1'b1};
        tbl[10] = '{16'h8000, 8'h80, 1'b1};
        tbl[11] = '{16'h0017, 8'h01, 1'b0};
        tbl[12] = '{16'h0018, 8'h02, 1'b0};

        rst        = 1'b0;
        din[0]     = '0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;

        // Power-on reset
        #12;
        check("por_out_valid", dout_valid, 0);
        check("por_out_last", dout_last, 0);
        check("por_sat_count", sat_count, 0);
        check("por_in_ready", din_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("por_release_ready", din_ready, 1);

        // Single-beat vectors: latency, rounding, clamping, sat counting
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            din[0]     = tbl[i].din;
            din_valid  = 1'b1;
            dout_ready = 1'b1;
            #1;
            check("vec_in_ready", din_ready, 1);
            @(posedge clk);
            @(negedge clk);
            din_valid = 1'b0;
            lat = 1;
            while (!dout_valid && lat < 8) begin
                @(posedge clk);
                @(negedge clk);
                lat++;
            end
            check("vec_latency", lat, 2);
            check("vec_data", $unsigned(dout[0]), tbl[i].dout);
            check("vec_last", dout_last, (out_idx % DEPTH) == DEPTH - 1);
            if (tbl[i].sat && SAT_EN) exp_sat++;
            out_idx++;
            @(posedge clk);
            @(negedge clk);
            check("vec_sat_count", sat_count, exp_sat);
            check("vec_drained", dout_valid, 0);
        end

        // Backpressure: 6 beats with the sink stalled for 5 cycles
        stim_q.delete();
        for (int i = 1; i <= 6; i++) stim_q.push_back(16'(i * 16));
        run_stream(2);

        // Random data with random valid/ready
        stim_q.delete();
        for (int i = 0; i < 60; i++) stim_q.push_back(16'($urandom_range(0, 65535)));
        run_stream(1);

        // Framing: 25 beats from a fresh frame
        apply_reset();
        last_hits = 0;
        stim_q.delete();
        for (int i = 0; i < 25; i++) stim_q.push_back(16'($urandom_range(0, 65535)));
        run_stream(0);
        check("frame_last_hits", last_hits, 2);

        // Reset with both stages full
        @(negedge clk);
        dout_ready = 1'b0;
        din_valid  = 1'b1;
        din[0]     = 16'h0100;
        @(posedge clk);
        @(negedge clk);
        din[0] = 16'h0200;
        @(posedge clk);
        @(negedge clk);
        din_valid = 1'b0;
        #1;
        check("full_in_ready", din_ready, 0);
        check("full_out_valid", dout_valid, 1);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_out_valid", dout_valid, 0);
        check("midrst_out_last", dout_last, 0);
        check("midrst_sat_count", sat_count, 0);
        check("midrst_in_ready", din_ready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        out_idx = 0;
        exp_sat = 0;
        @(posedge clk);
        #1;
        check("midrst_release_ready", din_ready, 1);

        // First frame after reset starts at index 0: last only on beat 10
        last_hits = 0;
        stim_q.delete();
        for (int i = 0; i < 10; i++) stim_q.push_back(16'($urandom_range(0, 65535)));
        run_stream(0);
        check("post_rst_last_hits", last_hits, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
